pc_fetch_ctrl: RTL and testbench

//  Owns the RISC-V program counter and sequences instruction fetch. Each cycle it

---
 rtl/pc_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// RISC-V program counter and instruction fetch sequencer (req/ready + valid imem port).
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect targets into a HALT state.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IReady,
  input  logic        IValid,
  input  logic [31:0] IRData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignErr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
`ifdef MISALIGN_TRAP_EN
  localparam logic [2:0] S_HALT = 3'd4;
`endif

  logic [2:0]  state;
  logic        kill;
  logic        redir_act;
  logic [31:0] target_raw;
  logic [31:0] target;

  // PCPlus4 is always the registered PC + 4, so it doubles as the sequential target.
  always_comb begin
    case (PCSrc)
      2'b01:   target_raw = PCTarget;
      2'b10:   target_raw = ALUResult & ~32'h1;
      default: target_raw = PCPlus4;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic target_bad;
  assign target     = target_raw;
  assign target_bad = |target_raw[1:0];
`else
  assign target      = target_raw & ~32'h3;
  assign MisalignErr = 1'b0;
`endif

  assign redir_act = Redirect && ((state == S_REQ) || (state == S_WAIT) || (state == S_RESP));
  assign IReq      = (state == S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kill       <= 1'b0;
      IAddr      <= RESET_PC;
      PC         <= RESET_PC;
      PCPlus4    <= RESET_PC + 32'd4;
      Instr      <= '0;
      InstrValid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      if (redir_act && target_bad) begin
        state       <= S_HALT;
        kill        <= 1'b0;
        InstrValid  <= 1'b0;
        MisalignErr <= 1'b1;
      end else
`endif
      if (redir_act) begin
        IAddr      <= target;
        InstrValid <= 1'b0;
        case (state)
          // A request accepted in the redirect cycle still returns data; mark it for discard.
          S_REQ: begin
            if (IReady) begin
              kill  <= 1'b1;
              state <= S_WAIT;
            end
          end
          // Wait out the in-flight response unless it lands this very cycle.
          S_WAIT: begin
            if (IValid) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill  <= 1'b1;
            end
          end
          default: state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_IDLE: state <= S_REQ;
          S_REQ: begin
            if (IReady) state <= S_WAIT;
          end
          S_WAIT: begin
            if (IValid) begin
              if (kill) begin
                kill  <= 1'b0;
                state <= S_REQ;
              end else begin
                Instr      <= IRData;
                PC         <= IAddr;
                PCPlus4    <= IAddr + 32'd4;
                InstrValid <= 1'b1;
                state      <= S_RESP;
              end
            end
          end
          S_RESP: begin
            if (!Stall) begin
              IAddr      <= PCPlus4;
              InstrValid <= 1'b0;
              state      <= S_REQ;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized run
// against a transaction-level model of the expected PC stream.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = '0;
  logic [31:0] ALUResult = '0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IReady = 1'b0;
  logic        IValid = 1'b0;
  logic [31:0] IRData = '0;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignErr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // imem responder state
  logic        outst = 1'b0;
  logic [31:0] rsp_addr = '0;
  int          cnt = 0;
  int          lat = 1;
  bit          rnd = 1'b0;
  bit          proto_err = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Redirect(Redirect), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .ALUResult(ALUResult), .IReq(IReq), .IAddr(IAddr),
    .IReady(IReady), .IValid(IValid), .IRData(IRData), .Instr(Instr),
    .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4), .MisalignErr(MisalignErr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock: imem model reacts to the handshake seen before the edge.
  task automatic step();
    logic acc, vld;
    logic [31:0] a;
    acc = IReq & IReady;
    vld = IValid;
    a   = IAddr;
    @(posedge clk); #1;
    cyc++;
    if (vld && outst) outst = 1'b0;
    if (acc) begin
      if (outst) proto_err = 1'b1;
      outst    = 1'b1;
      rsp_addr = a;
      cnt      = rnd ? int'($urandom_range(1, 3)) : lat;
    end
    IValid = 1'b0;
    IRData = 32'h0;
    if (outst) begin
      if (cnt <= 1) begin
        IValid = 1'b1;
        IRData = mem_word(rsp_addr);
      end else cnt--;
    end else if (rnd && $urandom_range(0, 3) == 0) begin
      IValid = 1'b1;
      IRData = 32'hDEAD_BEEF;
    end
    IReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_reset();
    Redirect = 1'b0; Stall = 1'b0; PCSrc = 2'b00; IValid = 1'b0; IReady = 1'b1;
    rnd = 1'b0; lat = 1; outst = 1'b0; proto_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_deliv(input int max, output bit ok);
    logic p;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      p = InstrValid;
      step();
      if (InstrValid && !p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (IReq !== 1'b0 || InstrValid !== 1'b0) begin
      bad++; $display("FAIL reset_idle: IReq=%b InstrValid=%b required 0 0", IReq, InstrValid);
    end
    lat = 3;
    step();
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h0) begin
      bad++; $display("FAIL reset_first_req: IReq=%b IAddr=%h required 1 00000000", IReq, IAddr);
    end
    step();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (IReq !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h0 || IAddr !== 32'h0 ||
        PCPlus4 !== 32'h4 || MisalignErr !== 1'b0 || Instr !== 32'h0) begin
      bad++; $display("FAIL reset_async: IReq=%b IV=%b PC=%h IAddr=%h PCPlus4=%h Err=%b Instr=%h required 0 0 0 0 4 0 0",
                      IReq, InstrValid, PC, IAddr, PCPlus4, MisalignErr, Instr);
    end
    outst = 1'b0; IValid = 1'b0; lat = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    total++;
    if (IReq !== 1'b0) begin
      bad++; $display("FAIL reset_release_idle: IReq=%b required 0", IReq);
    end
    step();
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h0) begin
      bad++; $display("FAIL reset_release_req: IReq=%b IAddr=%h required 1 00000000", IReq, IAddr);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    int t0, t1;
    do_reset();
    step();
    wait_deliv(10, ok);
    t0 = cyc;
    total++;
    if (!ok || PC !== 32'h0 || Instr !== 32'h0050_0093 || PCPlus4 !== 32'h4) begin
      bad++; $display("FAIL seq_first: ok=%b PC=%h Instr=%h PCPlus4=%h required 1 0 00500093 4", ok, PC, Instr, PCPlus4);
    end
    wait_deliv(10, ok);
    t1 = cyc;
    total++;
    if (!ok || PC !== 32'h4 || Instr !== 32'h0010_0113 || PCPlus4 !== 32'h8) begin
      bad++; $display("FAIL seq_second: ok=%b PC=%h Instr=%h PCPlus4=%h required 1 4 00100113 8", ok, PC, Instr, PCPlus4);
    end
    total++;
    if (t1 - t0 != 3) begin
      bad++; $display("FAIL seq_rate: interval=%0d required 3", t1 - t0);
    end
  endtask

  task automatic test_branch();
    bit ok, all;
    do_reset();
    step();
    all = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_deliv(10, ok);
      all &= ok;
    end
    total++;
    if (!all || PC !== 32'h10) begin
      bad++; $display("FAIL branch_setup: ok=%b PC=%h required 1 00000010", all, PC);
    end
    Redirect = 1'b1; PCSrc = 2'b01; PCTarget = 32'h18;
    step();
    Redirect = 1'b0;
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h18 || InstrValid !== 1'b0) begin
      bad++; $display("FAIL branch_addr: IReq=%b IAddr=%h IV=%b required 1 00000018 0", IReq, IAddr, InstrValid);
    end
    wait_deliv(10, ok);
    total++;
    if (!ok || PC !== 32'h18 || Instr !== mem_word(32'h18)) begin
      bad++; $display("FAIL branch_deliver: ok=%b PC=%h Instr=%h required 1 00000018 %h", ok, PC, Instr, mem_word(32'h18));
    end
    Redirect = 1'b1; PCSrc = 2'b01; PCTarget = 32'h0FFF_FFFC;
    step();
    Redirect = 1'b0;
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h0FFF_FFFC) begin
      bad++; $display("FAIL branch_addr2: IReq=%b IAddr=%h required 1 0ffffffc", IReq, IAddr);
    end
    wait_deliv(10, ok);
    total++;
    if (!ok || PC !== 32'h0FFF_FFFC || PCPlus4 !== 32'h1000_0000) begin
      bad++; $display("FAIL branch_deliver2: ok=%b PC=%h PCPlus4=%h required 1 0ffffffc 10000000", ok, PC, PCPlus4);
    end
  endtask

  task automatic test_kill();
    bit ok, seen_iv, got_req;
    do_reset();
    lat = 3;
    step();
    step();
    Redirect = 1'b1; PCSrc = 2'b10; ALUResult = 32'h101;
    step();
    Redirect = 1'b0; lat = 1;
    seen_iv = 1'b0; got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      if (InstrValid) seen_iv = 1'b1;
      if (IReq) got_req = 1'b1;
      else step();
    end
    total++;
    if (!got_req || seen_iv || IAddr !== 32'h100) begin
      bad++; $display("FAIL kill_drop: req=%b iv_seen=%b IAddr=%h required 1 0 00000100", got_req, seen_iv, IAddr);
    end
    wait_deliv(10, ok);
    total++;
    if (!ok || PC !== 32'h100 || Instr !== mem_word(32'h100)) begin
      bad++; $display("FAIL kill_deliver: ok=%b PC=%h Instr=%h required 1 00000100 %h", ok, PC, Instr, mem_word(32'h100));
    end
    step();
    step();
    Redirect = 1'b1; PCSrc = 2'b01; PCTarget = 32'h40;
    step();
    Redirect = 1'b0;
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h40 || InstrValid !== 1'b0 || PC !== 32'h100) begin
      bad++; $display("FAIL kill_same_cycle: IReq=%b IAddr=%h IV=%b PC=%h required 1 00000040 0 00000100",
                      IReq, IAddr, InstrValid, PC);
    end
    wait_deliv(10, ok);
    total++;
    if (!ok || PC !== 32'h40) begin
      bad++; $display("FAIL kill_same_deliver: ok=%b PC=%h required 1 00000040", ok, PC);
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    step();
    wait_deliv(10, ok);
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (!ok || InstrValid !== 1'b1 || PC !== 32'h0 || Instr !== 32'h0050_0093 || IReq !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d]: IV=%b PC=%h Instr=%h IReq=%b required 1 0 00500093 0",
                        i, InstrValid, PC, Instr, IReq);
      end
    end
    Stall = 1'b0;
    step();
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h4 || InstrValid !== 1'b0) begin
      bad++; $display("FAIL stall_release: IReq=%b IAddr=%h IV=%b required 1 00000004 0", IReq, IAddr, InstrValid);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    step();
    wait_deliv(10, ok);
    Redirect = 1'b1; PCSrc = 2'b01; PCTarget = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    wait_deliv(10, ok);
    total++;
    if (!ok || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_deliver: ok=%b PC=%h PCPlus4=%h required 1 fffffffc 0", ok, PC, PCPlus4);
    end
    step();
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: IReq=%b IAddr=%h required 1 00000000", IReq, IAddr);
    end
    wait_deliv(10, ok);
    Redirect = 1'b1; PCSrc = 2'b01; PCTarget = 32'h6;
    step();
    Redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (MisalignErr !== 1'b1 || IReq !== 1'b0 || InstrValid !== 1'b0) ok = 1'b0;
      step();
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL trap_halt: Err=%b IReq=%b IV=%b required 1 0 0", MisalignErr, IReq, InstrValid);
    end
    do_reset();
    total++;
    if (MisalignErr !== 1'b0) begin
      bad++; $display("FAIL trap_clear: Err=%b required 0", MisalignErr);
    end
`else
    total++;
    if (IReq !== 1'b1 || IAddr !== 32'h4 || MisalignErr !== 1'b0) begin
      bad++; $display("FAIL align_force: IReq=%b IAddr=%h Err=%b required 1 00000004 0", IReq, IAddr, MisalignErr);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, model_pc, t;
    bit prev_iv, prev_stall, prev_redir, held;
    int ndel;
    do_reset();
    step();
    rnd = 1'b1;
    exp_pc = 32'h0; model_pc = 32'h0; ndel = 0;
    prev_iv = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      held = prev_iv && prev_stall && !prev_redir;
      if (held) begin
        total++;
        if (InstrValid !== 1'b1 || PC !== model_pc || Instr !== mem_word(model_pc) || IReq !== 1'b0) begin
          bad++; $display("FAIL rnd_hold @%0d: IV=%b PC=%h Instr=%h IReq=%b required 1 %h %h 0",
                          cyc, InstrValid, PC, Instr, IReq, model_pc, mem_word(model_pc));
        end
      end else if (InstrValid) begin
        total++;
        if (prev_iv || PC !== exp_pc || Instr !== mem_word(exp_pc) || PCPlus4 !== exp_pc + 32'd4) begin
          bad++; $display("FAIL rnd_deliver @%0d: PC=%h Instr=%h PCPlus4=%h required %h %h %h",
                          cyc, PC, Instr, PCPlus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        model_pc = exp_pc;
        exp_pc   = exp_pc + 32'd4;
        ndel++;
      end
      Stall     = ($urandom_range(0, 2) == 0);
      Redirect  = ($urandom_range(0, 9) == 0);
      PCSrc     = 2'($urandom_range(0, 3));
      PCTarget  = $urandom;
      ALUResult = $urandom;
`ifdef MISALIGN_TRAP_EN
      PCTarget[1:0] = 2'b00;
      ALUResult[1]  = 1'b0;
`endif
      if (Redirect) begin
        case (PCSrc)
          2'b01:   t = PCTarget;
          2'b10:   t = ALUResult & ~32'h1;
          default: t = model_pc + 32'd4;
        endcase
        exp_pc = t & ~32'h3;
      end
      prev_iv = InstrValid; prev_stall = Stall; prev_redir = Redirect;
      step();
    end
    Redirect = 1'b0; Stall = 1'b0; rnd = 1'b0;
    total++;
    if (ndel < 100 || proto_err) begin
      bad++; $display("FAIL rnd_progress: deliveries=%0d proto_err=%b required >=100 0", ndel, proto_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_kill();
    test_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
